// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core control logic.
//
// Contents:
//   BT_BEQ..BT_BGE     encodings of the ALU decoder's BranchType field
//   FWD_RF/FWD_M/FWD_W EX-stage operand forward-select codes
//   hz_state_t         registered hazard-controller state (RUN/STALL/FLUSH)
package riscv_pkg;

  // Branch comparison kinds produced by the ALU decoder
  localparam logic [1:0] BT_BEQ = 2'b00;
  localparam logic [1:0] BT_BNE = 2'b01;
  localparam logic [1:0] BT_BLT = 2'b10;
  localparam logic [1:0] BT_BGE = 2'b11;

  // Operand source select for the EX-stage ALU inputs
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  // Hazard controller state, visible on the hz_state port
  typedef enum logic [1:0] {
    HZ_RUN   = 2'b00,
    HZ_STALL = 2'b01,
    HZ_FLUSH = 2'b10
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_branch_cond.sv
// branch_cond: evaluates a conditional branch from the ALU flags.
//
// Ports:
//   BranchTypeE  in  2  00 beq, 01 bne, 10 blt, 11 bge
//   ZeroE        in  1  ALU result == 0
//   LtE          in  1  signed less-than result of the ALU
//   taken        out 1  branch condition holds
//
// Kept as its own module so an early-branch-in-D variant can reuse it.
module branch_cond
  import riscv_pkg::*;
(
  input  logic [1:0] BranchTypeE,
  input  logic       ZeroE,
  input  logic       LtE,
  output logic       taken
);

  // beq/bne test the zero flag, blt/bge test the signed less-than flag
  always_comb begin
    taken = 1'b0;
    case (BranchTypeE)
      BT_BEQ:  taken = ZeroE;
      BT_BNE:  taken = ~ZeroE;
      BT_BLT:  taken = LtE;
      BT_BGE:  taken = ~LtE;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage RISC-V core.
//
// Selects EX-stage operand forwarding, detects load-use stalls, resolves
// branches/jumps in EX and drives PC redirect, stalls and flushes. Keeps a
// registered hazard state and saturating stall/flush event counters.
//
// Parameters:
//   CNT_W  width of the stall/flush event counters
//   REG_AW register-index width
//
// Ports:
//   clk, reset               clock (rising edge), async active-high reset
//   Rs1D, Rs2D               source registers of the instruction in D
//   Rs1E, Rs2E               source registers of the instruction in E
//   RdE, RdM, RdW            destination registers in E/M/W
//   LoadE                    E-stage instruction is a load
//   RegWriteM, RegWriteW     M/W stages write the register file
//   BranchE, JumpE           E-stage conditional branch / jal-jalr
//   BranchTypeE, ZeroE, LtE  branch kind and ALU flags
//   ForwardAE, ForwardBE     operand source select (00 RF, 10 M, 01 W)
//   StallF, StallD           hold PC / IF-ID register
//   FlushD, FlushE           bubble IF-ID / ID-EX register
//   PCSrcE                   take branch/jump target
//   hz_state                 registered state 00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt, flush_cnt     saturating event counters
//
// Configuration macro HAZARD_PERF_EN: when defined, stall_cnt counts cycles
// with StallD=1 and flush_cnt counts cycles with PCSrcE=1, both saturating.
// When undefined, no counter flops exist and both outputs read 0.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              LoadE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [1:0]        BranchTypeE,
  input  logic              ZeroE,
  input  logic              LtE,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic              PCSrcE,
  output logic [1:0]        hz_state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hz_state_t state;
  hz_state_t stateNext;
  logic      takenE;
  logic      lwStall;
  logic      stallEvt;

  branch_cond u_branch_cond (
    .BranchTypeE (BranchTypeE),
    .ZeroE       (ZeroE),
    .LtE         (LtE),
    .taken       (takenE)
  );

  assign PCSrcE  = JumpE | (BranchE & takenE);
  assign lwStall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  // A redirect already discards the D-stage instruction, so stalling it
  // as well would only add a second bubble.
  assign stallEvt = lwStall & ~PCSrcE;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= HZ_RUN;
    end else begin
      state <= stateNext;
    end
  end

  // Next state depends only on the current cycle's hazards, so a stall
  // lasts exactly as long as the load-use condition is seen and any state
  // falls back to RUN once no hazard is present.
  always_comb begin
    stateNext = HZ_RUN;
    if (PCSrcE) begin
      stateNext = HZ_FLUSH;
    end else if (stallEvt) begin
      stateNext = HZ_STALL;
    end
  end

  // Combinational outputs: forwarding with M priority over W, and the
  // stall/flush controls.
  always_comb begin
    ForwardAE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E)) begin
      ForwardAE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs1E)) begin
      ForwardAE = FWD_W;
    end

    ForwardBE = FWD_RF;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E)) begin
      ForwardBE = FWD_M;
    end else if (RegWriteW && (RdW != '0) && (RdW == Rs2E)) begin
      ForwardBE = FWD_W;
    end

    StallF = stallEvt;
    StallD = stallEvt;
    FlushE = lwStall | PCSrcE;
    FlushD = PCSrcE;
  end

  assign hz_state = state;

`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Event counters stop at all-ones instead of wrapping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (StallD && (stallCnt != '1)) begin
        stallCnt <= stallCnt + CNT_ONE;
      end
      if (PCSrcE && (flushCnt != '1)) begin
        flushCnt <= flushCnt + CNT_ONE;
      end
    end
  end

  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed cases with literal expectations plus a
// randomized phase, all checked each cycle against a behavioural model.
// Counters are built narrow (CNT_W=4) so saturation is reachable quickly.
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int REG_AW  = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef HAZARD_PERF_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              LoadE, RegWriteM, RegWriteW, BranchE, JumpE;
  logic [1:0]        BranchTypeE;
  logic              ZeroE, LtE;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              StallF, StallD, FlushD, FlushE, PCSrcE;
  logic [1:0]        hz_state;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model registered state: 0 RUN, 1 STALL, 2 FLUSH
  int mState    = 0;
  int mStallCnt = 0;
  int mFlushCnt = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .LoadE(LoadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .BranchE(BranchE), .JumpE(JumpE), .BranchTypeE(BranchTypeE),
    .ZeroE(ZeroE), .LtE(LtE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .PCSrcE(PCSrcE), .hz_state(hz_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules
  function automatic int fwdSel(input logic we, input int rd, input int rs1M,
                                input logic weW, input int rdW);
    if (we && rd != 0 && rd == rs1M) return 2;
    if (weW && rdW != 0 && rdW == rs1M) return 1;
    return 0;
  endfunction

  function automatic bit mRedirect();
    bit cond;
    cond = BranchTypeE[1] ? LtE : ZeroE;
    return JumpE || (BranchE && (cond ^ BranchTypeE[0]));
  endfunction

  function automatic bit mLoadUse();
    return LoadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
  endfunction

  // Model of the registered state and counters
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mState = 0; mStallCnt = 0; mFlushCnt = 0;
    end else begin
      bit red, stl;
      red = mRedirect();
      stl = mLoadUse() && !red;
      mState = red ? 2 : (stl ? 1 : 0);
      if (PERF_EN && stl && mStallCnt < CNT_MAX) mStallCnt++;
      if (PERF_EN && red && mFlushCnt < CNT_MAX) mFlushCnt++;
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    bit red, lw;
    red = mRedirect();
    lw  = mLoadUse();
    checkOutput("m_ForwardAE", int'(ForwardAE), fwdSel(RegWriteM, RdM, Rs1E, RegWriteW, RdW));
    checkOutput("m_ForwardBE", int'(ForwardBE), fwdSel(RegWriteM, RdM, Rs2E, RegWriteW, RdW));
    checkOutput("m_PCSrcE", int'(PCSrcE), int'(red));
    checkOutput("m_StallF", int'(StallF), int'(lw && !red));
    checkOutput("m_StallD", int'(StallD), int'(lw && !red));
    checkOutput("m_FlushD", int'(FlushD), int'(red));
    checkOutput("m_FlushE", int'(FlushE), int'(lw || red));
    checkOutput("m_hz_state", int'(hz_state), mState);
    checkOutput("m_stall_cnt", int'(stall_cnt), mStallCnt);
    checkOutput("m_flush_cnt", int'(flush_cnt), mFlushCnt);
  end

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
    RdE = '0; RdM = '0; RdW = '0;
    LoadE = 0; RegWriteM = 0; RegWriteW = 0; BranchE = 0; JumpE = 0;
    BranchTypeE = 2'b00; ZeroE = 0; LtE = 0;
  endtask

  // Random stimulus with small register indices so matches are common
  task automatic applyStimulus();
    Rs1D = REG_AW'($urandom_range(0, 7)); Rs2D = REG_AW'($urandom_range(0, 7));
    Rs1E = REG_AW'($urandom_range(0, 7)); Rs2E = REG_AW'($urandom_range(0, 7));
    RdE  = REG_AW'($urandom_range(0, 7)); RdM  = REG_AW'($urandom_range(0, 7));
    RdW  = REG_AW'($urandom_range(0, 7));
    LoadE     = ($urandom_range(0, 2) == 0);
    RegWriteM = ($urandom_range(0, 1) == 0);
    RegWriteW = ($urandom_range(0, 1) == 0);
    BranchE   = ($urandom_range(0, 3) == 0);
    JumpE     = ($urandom_range(0, 7) == 0);
    BranchTypeE = 2'($urandom_range(0, 3));
    ZeroE = 1'($urandom_range(0, 1));
    LtE   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [15:0] takenTbl;
    int idx;
    takenTbl = 16'b0101_1010_0011_1100;

    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_hz_state", int'(hz_state), 0);
    checkOutput("rst_stall_cnt", int'(stall_cnt), 0);
    checkOutput("rst_flush_cnt", int'(flush_cnt), 0);
    reset = 1'b0;

    // Forwarding: M beats W, r0 never forwards
    RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5;
    #1 checkOutput("fwd_m_over_w", int'(ForwardAE), 2);
    RdM = 0; RdW = 0; Rs1E = 0;
    #1 checkOutput("fwd_r0", int'(ForwardAE), 0);
    RdM = 3; RdW = 6; Rs2E = 6;
    #1 checkOutput("fwd_b_w", int'(ForwardBE), 1);
    @(posedge clk); #1 clearInputs();

    // Load-use stall
    LoadE = 1; RdE = 7; Rs2D = 7;
    #1;
    checkOutput("lw_StallF", int'(StallF), 1);
    checkOutput("lw_StallD", int'(StallD), 1);
    checkOutput("lw_FlushE", int'(FlushE), 1);
    checkOutput("lw_FlushD", int'(FlushD), 0);
    @(posedge clk); #1;
    checkOutput("lw_hz_state", int'(hz_state), 1);
    checkOutput("lw_stall_cnt", int'(stall_cnt), PERF_EN ? 1 : 0);
    clearInputs();
    @(posedge clk); #1;
    checkOutput("lw_back_to_run", int'(hz_state), 0);

    // Branch condition table
    for (int bt = 0; bt < 4; bt++) begin
      for (int zl = 0; zl < 4; zl++) begin
        @(posedge clk); #1;
        clearInputs();
        BranchE = 1; BranchTypeE = 2'(bt); ZeroE = zl[1]; LtE = zl[0];
        idx = bt * 4 + zl;
        #1 checkOutput($sformatf("br_bt%0d_z%0d_l%0d", bt, zl / 2, zl % 2),
                       int'(PCSrcE), int'(takenTbl[idx]));
      end
    end

    // Load-use hazard together with a jump: redirect wins
    @(posedge clk); #1 clearInputs();
    LoadE = 1; RdE = 3; Rs1D = 3; JumpE = 1;
    #1;
    checkOutput("lwj_PCSrcE", int'(PCSrcE), 1);
    checkOutput("lwj_FlushD", int'(FlushD), 1);
    checkOutput("lwj_FlushE", int'(FlushE), 1);
    checkOutput("lwj_StallF", int'(StallF), 0);
    checkOutput("lwj_StallD", int'(StallD), 0);
    @(posedge clk); #1;
    checkOutput("lwj_hz_state", int'(hz_state), 2);

    // Back-to-back redirects saturate the flush counter
    clearInputs();
    JumpE = 1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("sat_flush_cnt", int'(flush_cnt), PERF_EN ? CNT_MAX : 0);
    checkOutput("sat_hz_flush", int'(hz_state), 2);

    // Asynchronous reset during a stall
    clearInputs();
    @(posedge clk); #1;
    LoadE = 1; RdE = 9; Rs1D = 9;
    @(posedge clk); #1;
    checkOutput("rs_pre_stall", int'(hz_state), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rs_hz_state", int'(hz_state), 0);
    checkOutput("rs_stall_cnt", int'(stall_cnt), 0);
    checkOutput("rs_flush_cnt", int'(flush_cnt), 0);
    @(posedge clk); #1;
    clearInputs();
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rs_release_run", int'(hz_state), 0);

    // Randomized phase with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      applyStimulus();
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
